array_13_port_ctrl: RTL and testbench
=====================================

// Module: array_13_port_ctrl
// PURPOSE
//   Request-side controller for the 128x160 single-port masked array (7b addr, 4x40b lanes, 1-cycle read).
//   Merges independent read and write valid/ready channels onto the single RW port.
//   Captures the array's next-cycle read data into a 2-entry response FIFO, so reads can issue every cycle.
//   Sits directly upstream of the array macro; consumers see only the valid/ready request and response channels.
// PARAMETERS
//   DEPTH        128  array entries; address width is clog2(DEPTH)=7
//   LANE_W       40   bits per write-mask lane
//   LANES        4    mask lanes; data width = LANES*LANE_W = 160
//   STARVE_LIMIT 4    consecutive cycles a pending read may lose to writes before it wins
// PORTS
//   clock        in   1    single clock for the controller and the array
//   reset        in   1    synchronous, active-high
//   rd_valid     in   1    read request valid
//   rd_ready     out  1    read request accepted when rd_valid&rd_ready
//   rd_addr      in   7    read address
//   wr_valid     in   1    write request valid
//   wr_ready     out  1    write request accepted when wr_valid&wr_ready
//   wr_addr      in   7    write address
//   wr_mask      in   4    lane enables; bit i covers data[i*40+:40]
//   wr_data      in   160  write data
//   resp_valid   out  1    read data available
//   resp_ready   in   1    consumer takes resp_data when resp_valid&resp_ready
//   resp_data    out  160  read data, in request order
//   arr_en       out  1    to array port enable
//   arr_wmode    out  1    1=write, 0=read
//   arr_addr     out  7    to array address
//   arr_wmask    out  4    to array write mask
//   arr_wdata    out  160  to array write data
//   arr_rdata    in   160  from array; valid the cycle after a read issue
// BEHAVIOUR
//   Reset values: rd_ready=0, wr_ready=0, resp_valid=0, arr_en=0, arr_wmode=0. FIFO count, inflight flag and starve counter are 0.
//   arr_* outputs are combinational from the grant, so a request accepted in cycle T drives the array in cycle T.
//   Read credit: rd_ok = (fifo_cnt - deq_now + inflight) < 2, where deq_now = resp_valid&resp_ready.
//   Grant, evaluated each cycle in RUN:
//     - Write wins if wr_valid and (!rd_valid or !rd_ok or starve_cnt < STARVE_LIMIT).
//     - Otherwise the read wins if rd_valid and rd_ok.
//     - The two ready signals are never high together.
//   starve_cnt:
//     - Increments when rd_valid&rd_ok and the write wins.
//     - Clears on a read grant or when !rd_valid.
//     - Saturates at STARVE_LIMIT.
//   Read issued at T: inflight=1 at T+1, and arr_rdata is pushed into the FIFO at T+1.
//     - resp_valid is asserted no earlier than T+1 (combinational bypass when the FIFO is empty).
//     - Minimum latency is 1 cycle; sustained throughput is 1 read/cycle while resp_ready=1.
//   Write with wr_mask==0: accepted (wr_ready=1 per grant rules), but arr_en stays 0 and no array access occurs.
//   Same-cycle read and write to the same address: only one is granted, so ordering is grant order (write first unless starved).
//   FIFO full (cnt=2 and inflight=0) with no dequeue: rd_ready=0 and writes proceed.
//   The credit rule guarantees the FIFO never overflows.
//   Reset asserted mid-operation: the in-flight read is dropped (arr_rdata not pushed), the FIFO is flushed, and resp_valid=0 next cycle.
// CONFIGURATION
//   ARRAY_13_INIT_EN defined:
//     - After reset deassertion an INIT state writes all-zero data, wmask=4'hF, to addr 0..DEPTH-1, one per cycle (128 cycles).
//     - During INIT rd_ready=wr_ready=0. The state then moves INIT->RUN.
//     - Reset during INIT restarts at addr 0.
//   ARRAY_13_INIT_EN undefined:
//     - The controller enters RUN the first cycle after reset.
//     - Array contents are undefined until written.
// STRUCTURE
//   Package array_13_pkg: DEPTH, ADDR_W=7, LANE_W, LANES, DATA_W=160, and typedef state_e {ST_INIT, ST_RUN}.
//   Sub-module array_13_resp_fifo2: 2-entry 160b FIFO (push, pop, count, bypass when empty).
//   Arbiter, credit logic, starve counter and INIT sweep live in the top module.
// TESTING
//   1. Back-to-back reads of addr 0..3 with resp_ready=1 -> one rd accept/cycle; resp_data in order, each 1 cycle after its accept.
//   2. Write addr 5, mask 4'b0101, data all-ones over zeros -> read addr 5 returns lanes 0 and 2 = 40'hFF_FFFF_FFFF, lanes 1 and 3 = 0.
//   3. resp_ready=0 with reads pending -> exactly 2 reads accepted, then rd_ready=0; one pop -> exactly one more read accepted.
//   4. wr_valid=1 continuously with rd_valid=1 -> read granted on the 5th cycle (STARVE_LIMIT=4), then writes resume.
//   5. Reset pulsed the cycle after a read accept -> no resp_valid afterwards; a subsequent read returns correct data.
//   6. With ARRAY_13_INIT_EN -> 128 zero writes with rd/wr_ready=0, rd_ready high at cycle 129, then a read of addr 127 returns 0.

Source files
------------

// File: rtl/array_13_pkg.sv
// rtl/array_13_pkg.sv - shared sizes and controller state type for the array_13 port controller
package array_13_pkg;
  localparam int DEPTH        = 128;
  localparam int ADDR_W       = $clog2(DEPTH);
  localparam int LANE_W       = 40;
  localparam int LANES        = 4;
  localparam int DATA_W       = LANES * LANE_W;
  localparam int STARVE_LIMIT = 4;
  localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;
endpackage

// File: rtl/array_13_resp_fifo2.sv
// rtl/array_13_resp_fifo2.sv - 2-entry read response FIFO with combinational bypass when empty
module array_13_resp_fifo2
  import array_13_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        count_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);
  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              store, drain;

  assign valid_o = (count_q != 2'd0) || push_i;
  assign data_o  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : push_data_i;
  assign count_o = count_q;

  // A push that is popped in the same cycle while empty passes straight through.
  assign store = push_i && !(pop_i && (count_q == 2'd0));
  assign drain = pop_i && (count_q != 2'd0);

  always_comb begin
    count_d = count_q + {1'b0, store} - {1'b0, drain};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (store) wr_ptr_q <= ~wr_ptr_q;
      if (drain) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/array_13_port_ctrl.sv
// rtl/array_13_port_ctrl.sv - read/write arbiter onto a single-port masked array; ARRAY_13_INIT_EN adds a zeroing sweep
module array_13_port_ctrl
  import array_13_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LANES-1:0]  wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              arr_en,
  output logic              arr_wmode,
  output logic [ADDR_W-1:0] arr_addr,
  output logic [LANES-1:0]  arr_wmask,
  output logic [DATA_W-1:0] arr_wdata,
  input  logic [DATA_W-1:0] arr_rdata
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
  logic                inflight_q;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [1:0]          fifo_cnt;
  logic                fifo_valid;
  logic [DATA_W-1:0]   fifo_data;
  logic                run, init_act, deq_now, rd_ok, wr_win, rd_win;
  logic [2:0]          occ;

  assign run        = (state_q == ST_RUN) && !reset;
  assign init_act   = (state_q == ST_INIT) && !reset;
  assign resp_valid = fifo_valid && !reset;
  assign resp_data  = fifo_data;
  assign deq_now    = resp_valid && resp_ready;

  // Credit counts stored responses plus the read whose data lands next cycle.
  assign occ    = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, deq_now};
  assign rd_ok  = occ < 3'd2;
  assign wr_win = run && wr_valid &&
                  (!rd_valid || !rd_ok || (starve_q < STARVE_W'(STARVE_LIMIT)));
  assign rd_win = run && !wr_win && rd_valid && rd_ok;

  assign wr_ready = wr_win;
  assign rd_ready = rd_win;

  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef ARRAY_13_INIT_EN
      state_q <= ST_INIT;
`else
      state_q <= ST_RUN;
`endif
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
`ifdef ARRAY_13_INIT_EN
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + ADDR_W'(1);
      if (init_addr_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
    end
`else
    state_d = ST_RUN;
`endif
  end

  always_comb begin
    arr_en    = 1'b0;
    arr_wmode = 1'b0;
    arr_addr  = rd_addr;
    arr_wmask = wr_mask;
    arr_wdata = wr_data;
    if (init_act) begin
      arr_en    = 1'b1;
      arr_wmode = 1'b1;
      arr_addr  = init_addr_q;
      arr_wmask = '1;
      arr_wdata = '0;
    end else if (wr_win) begin
      // An all-zero mask is still a handshake, just without touching the array.
      arr_en    = |wr_mask;
      arr_wmode = 1'b1;
      arr_addr  = wr_addr;
    end else if (rd_win) begin
      arr_en    = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!rd_valid || rd_win) begin
      starve_d = '0;
    end else if (rd_ok && wr_win && (starve_q < STARVE_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      inflight_q <= rd_win;
      starve_q   <= starve_d;
    end
  end

  array_13_resp_fifo2 u_resp_fifo (
    .clk_i       (clock),
    .rst_i       (reset),
    .push_i      (inflight_q),
    .push_data_i (arr_rdata),
    .pop_i       (deq_now),
    .count_o     (fifo_cnt),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data)
  );
endmodule

// File: tb/tb_array_13_port_ctrl.sv
// tb/tb_array_13_port_ctrl.sv - scenario and randomized bench for array_13_port_ctrl with array and reference models
module tb_array_13_port_ctrl;
  import array_13_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              rd_valid, rd_ready, wr_valid, wr_ready;
  logic [ADDR_W-1:0] rd_addr, wr_addr, arr_addr;
  logic [LANES-1:0]  wr_mask, arr_wmask;
  logic [DATA_W-1:0] wr_data, resp_data, arr_wdata, arr_rdata;
  logic              resp_valid, resp_ready, arr_en, arr_wmode;

  logic [DATA_W-1:0] amem    [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q   [$];
  logic              load_mem = 1'b1;
  int                outst = 0;
  int                checks = 0;
  int                errors = 0;

  localparam logic [DATA_W-1:0] MASKED_EXP = {40'h0, {40{1'b1}}, 40'h0, {40{1'b1}}};

  typedef struct {
    bit                ra, wa, dq, rr, wr, rv, qempty;
    logic [DATA_W-1:0] rdat, expd, wd;
    logic              en, wm;
    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  mask;
    int                outst;
  } obs_t;

  always #5 clock = ~clock;

  array_13_port_ctrl dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_mask(wr_mask), .wr_data(wr_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .arr_en(arr_en), .arr_wmode(arr_wmode), .arr_addr(arr_addr),
    .arr_wmask(arr_wmask), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata)
  );

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Array macro: masked write, registered read, garbage when not reading.
  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < DEPTH; i++) amem[i] <= ref_mem[i];
    end else if (arr_en && arr_wmode) begin
      for (int i = 0; i < LANES; i++)
        if (arr_wmask[i]) amem[arr_addr][i*LANE_W +: LANE_W] <= arr_wdata[i*LANE_W +: LANE_W];
    end
    arr_rdata <= (arr_en && !arr_wmode && !load_mem) ? amem[arr_addr] : rand_data();
  end

  task automatic idle();
    rd_valid   = 1'b0;
    wr_valid   = 1'b0;
    resp_ready = 1'b1;
  endtask

  task automatic advance(output obs_t o);
    @(negedge clock);
    o.ra = rd_valid && rd_ready;  o.wa = wr_valid && wr_ready;
    o.dq = resp_valid && resp_ready;
    o.rr = rd_ready;  o.wr = wr_ready;  o.rv = resp_valid;
    o.rdat = resp_data;  o.en = arr_en;  o.wm = arr_wmode;  o.addr = arr_addr;
    o.mask = arr_wmask;  o.wd = arr_wdata;  o.outst = outst;
    o.qempty = 1'b0;  o.expd = '0;
    if (o.dq) begin
      if (exp_q.size() == 0) o.qempty = 1'b1;
      else o.expd = exp_q.pop_front();
      outst--;
    end
    if (o.wa)
      for (int i = 0; i < LANES; i++)
        if (wr_mask[i]) ref_mem[wr_addr][i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
    if (o.ra) begin
      exp_q.push_back(ref_mem[rd_addr]);
      outst++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic finish_init();
    obs_t o;
`ifdef ARRAY_13_INIT_EN
    repeat (DEPTH) advance(o);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b1;  rd_valid = 1'b1;  wr_valid = 1'b1;  resp_ready = 1'b1;
    rd_addr = 7'd3;  wr_addr = 7'd4;  wr_mask = 4'hF;  wr_data = rand_data();
    advance(o);
    advance(o);
    checks++; if (o.rr !== 1'b0) $display("FAIL reset_rd_ready: got %0b want 0", o.rr);
    checks++; if (o.wr !== 1'b0) $display("FAIL reset_wr_ready: got %0b want 0", o.wr);
    checks++; if (o.rv !== 1'b0) $display("FAIL reset_resp_valid: got %0b want 0", o.rv);
    checks++; if (o.en !== 1'b0) $display("FAIL reset_arr_en: got %0b want 0", o.en);
    checks++; if (o.wm !== 1'b0) $display("FAIL reset_arr_wmode: got %0b want 0", o.wm);
    errors += int'(o.rr !== 1'b0) + int'(o.wr !== 1'b0) + int'(o.rv !== 1'b0) +
              int'(o.en !== 1'b0) + int'(o.wm !== 1'b0);
    reset = 1'b0;  idle();  exp_q.delete();  outst = 0;
    finish_init();
    rd_valid = 1'b1;  rd_addr = 7'd3;
    advance(o);
    checks++; if (o.ra !== 1'b1) begin errors++; $display("FAIL first_rd_grant: got %0b want 1", o.ra); end
    rd_valid = 1'b0;
    advance(o);
    checks++;
    if (!o.dq || o.qempty || o.rdat !== o.expd) begin
      errors++; $display("FAIL first_rd_data: valid %0b got %0h want %0h", o.dq, o.rdat, o.expd);
    end
  endtask

`ifdef ARRAY_13_INIT_EN
  task automatic test_init();
    obs_t o;
    reset = 1'b1;  rd_valid = 1'b1;  rd_addr = 7'd127;  wr_valid = 1'b1;
    wr_addr = 7'd1;  wr_mask = 4'hF;  wr_data = rand_data();  resp_ready = 1'b1;
    advance(o);
    advance(o);
    reset = 1'b0;  exp_q.delete();  outst = 0;
    for (int c = 0; c < DEPTH; c++) begin
      advance(o);
      checks++;
      if (o.rr !== 1'b0 || o.wr !== 1'b0) begin
        errors++; $display("FAIL init_ready c%0d: rd %0b wr %0b want 0 0", c, o.rr, o.wr);
      end
      checks++;
      if (o.en !== 1'b1 || o.wm !== 1'b1 || o.addr !== ADDR_W'(c) || o.mask !== 4'hF || o.wd !== '0) begin
        errors++; $display("FAIL init_write c%0d: en %0b wm %0b addr %0d mask %0h want 1 1 %0d f", c, o.en, o.wm, o.addr, o.mask, c);
      end
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    wr_valid = 1'b0;
    advance(o);
    checks++; if (o.ra !== 1'b1) begin errors++; $display("FAIL init_run_rd_ready: got %0b want 1", o.ra); end
    rd_valid = 1'b0;
    advance(o);
    checks++;
    if (!o.dq || o.rdat !== '0) begin
      errors++; $display("FAIL init_read127: valid %0b got %0h want 0", o.dq, o.rdat);
    end
  endtask
`endif

  task automatic test_back_to_back();
    obs_t o;
    idle();
    for (int a = 0; a < 4; a++) begin
      wr_valid = 1'b1;  wr_addr = ADDR_W'(a);  wr_mask = 4'hF;  wr_data = rand_data();
      advance(o);
      checks++; if (o.wa !== 1'b1) begin errors++; $display("FAIL b2b_wr_accept a%0d: got %0b want 1", a, o.wa); end
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rd_valid = (k < 4);  rd_addr = ADDR_W'(k);
      advance(o);
      checks++;
      if (o.ra !== (k < 4)) begin errors++; $display("FAIL b2b_rd_accept k%0d: got %0b want %0b", k, o.ra, k < 4); end
      checks++;
      if (o.dq !== (k >= 1)) begin errors++; $display("FAIL b2b_resp_timing k%0d: got %0b want %0b", k, o.dq, k >= 1); end
      if (o.dq) begin
        checks++;
        if (o.qempty || o.rdat !== o.expd) begin
          errors++; $display("FAIL b2b_resp_data k%0d: got %0h want %0h", k, o.rdat, o.expd);
        end
      end
    end
    rd_valid = 1'b0;
  endtask

  task automatic test_masked_write();
    obs_t o;
    idle();
    wr_valid = 1'b1;  wr_addr = 7'd5;  wr_mask = 4'hF;  wr_data = '0;
    advance(o);
    wr_mask = 4'b0101;  wr_data = '1;
    advance(o);
    checks++;
    if (o.wa !== 1'b1 || o.en !== 1'b1 || o.wm !== 1'b1 || o.mask !== 4'b0101 || o.addr !== 7'd5) begin
      errors++; $display("FAIL mask_write_port: wa %0b en %0b wm %0b mask %0h addr %0d want 1 1 1 5 5", o.wa, o.en, o.wm, o.mask, o.addr);
    end
    wr_mask = 4'h0;  wr_data = rand_data();
    advance(o);
    checks++;
    if (o.wa !== 1'b1 || o.en !== 1'b0) begin
      errors++; $display("FAIL zero_mask_write: wa %0b en %0b want 1 0", o.wa, o.en);
    end
    wr_valid = 1'b0;  rd_valid = 1'b1;  rd_addr = 7'd5;
    advance(o);
    rd_valid = 1'b0;
    advance(o);
    checks++;
    if (!o.dq || o.rdat !== MASKED_EXP) begin
      errors++; $display("FAIL masked_read: valid %0b got %0h want %0h", o.dq, o.rdat, MASKED_EXP);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    int   n, got;
    idle();  resp_ready = 1'b0;  rd_valid = 1'b1;  n = 0;
    for (int k = 0; k < 6; k++) begin
      rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      advance(o);
      n += int'(o.ra);
    end
    checks++; if (n != 2 || o.rr !== 1'b0) begin errors++; $display("FAIL bp_accepts: got %0d rd_ready %0b want 2 0", n, o.rr); end
    resp_ready = 1'b1;  rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
    advance(o);
    checks++;
    if (!o.dq || o.qempty || o.rdat !== o.expd) begin errors++; $display("FAIL bp_pop_data: got %0h want %0h", o.rdat, o.expd); end
    checks++; if (o.ra !== 1'b1) begin errors++; $display("FAIL bp_pop_credit: got %0b want 1", o.ra); end
    resp_ready = 1'b0;  n = 0;
    for (int k = 0; k < 4; k++) begin
      advance(o);
      n += int'(o.ra);
    end
    checks++; if (n != 0) begin errors++; $display("FAIL bp_refill: got %0d want 0", n); end
    rd_valid = 1'b0;  resp_ready = 1'b1;  got = 0;
    for (int k = 0; k < 6; k++) begin
      advance(o);
      if (o.dq) begin
        got++;
        checks++;
        if (o.qempty || o.rdat !== o.expd) begin errors++; $display("FAIL bp_drain_data: got %0h want %0h", o.rdat, o.expd); end
      end
    end
    checks++; if (got != 2) begin errors++; $display("FAIL bp_drain_count: got %0d want 2", got); end
  endtask

  task automatic test_starve();
    obs_t o;
    idle();
    advance(o);
    wr_valid = 1'b1;  rd_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));  wr_mask = LANES'($urandom_range(1, 15));
      wr_data = rand_data();  rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      advance(o);
      checks++;
      if (o.ra !== (k == 4) || o.wa !== (k != 4)) begin
        errors++; $display("FAIL starve_grant k%0d: rd %0b wr %0b want %0b %0b", k, o.ra, o.wa, k == 4, k != 4);
      end
      if (o.dq) begin
        checks++;
        if (o.qempty || o.rdat !== o.expd) begin errors++; $display("FAIL starve_data: got %0h want %0h", o.rdat, o.expd); end
      end
    end
    idle();
    for (int k = 0; k < 3 && outst > 0; k++) advance(o);
    checks++; if (outst != 0) begin errors++; $display("FAIL starve_outstanding: got %0d want 0", outst); end
  endtask

  task automatic test_reset_midread();
    obs_t o;
    idle();
    rd_valid = 1'b1;  rd_addr = 7'd9;
    advance(o);
    checks++; if (o.ra !== 1'b1) begin errors++; $display("FAIL mid_rd_accept: got %0b want 1", o.ra); end
    rd_valid = 1'b0;  reset = 1'b1;
    advance(o);
    reset = 1'b0;  exp_q.delete();  outst = 0;
    finish_init();
    for (int k = 0; k < 3; k++) begin
      advance(o);
      checks++; if (o.rv !== 1'b0) begin errors++; $display("FAIL mid_stale_resp k%0d: got %0b want 0", k, o.rv); end
    end
    rd_valid = 1'b1;  rd_addr = 7'd9;
    advance(o);
    rd_valid = 1'b0;
    advance(o);
    checks++;
    if (!o.dq || o.qempty || o.rdat !== o.expd) begin
      errors++; $display("FAIL mid_reread: valid %0b got %0h want %0h", o.dq, o.rdat, o.expd);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int   losses;
    bit   credit, exp_wa, exp_ra;
    idle();
    advance(o);
    losses = 0;
    for (int c = 0; c < 1500; c++) begin
      rd_valid = ($urandom_range(0, 3) != 0);  wr_valid = $urandom_range(0, 1) != 0;
      rd_addr = ADDR_W'($urandom_range(0, 7));  wr_addr = ADDR_W'($urandom_range(0, 7));
      wr_mask = LANES'($urandom_range(0, 15));  wr_data = rand_data();
      resp_ready = ($urandom_range(0, 3) != 0);
      advance(o);
      credit = (o.outst - int'(o.dq)) < 2;
      exp_wa = wr_valid && (!rd_valid || !credit || losses < STARVE_LIMIT);
      exp_ra = rd_valid && credit && !exp_wa;
      checks++;
      if (o.wa !== exp_wa || o.ra !== exp_ra) begin
        errors++; $display("FAIL rnd_grant c%0d: wr %0b rd %0b want %0b %0b", c, o.wa, o.ra, exp_wa, exp_ra);
      end
      checks++; if (o.rr && o.wr) begin errors++; $display("FAIL rnd_both_ready c%0d: got 1 1 want not both", c); end
      checks++; if (outst > 2) begin errors++; $display("FAIL rnd_overflow c%0d: got %0d want <=2", c, outst); end
      if (o.dq) begin
        checks++;
        if (o.qempty || o.rdat !== o.expd) begin errors++; $display("FAIL rnd_data c%0d: got %0h want %0h", c, o.rdat, o.expd); end
      end
      if (o.wa) begin
        checks++;
        if (o.en !== (wr_mask != 0) || (wr_mask != 0 && (o.wm !== 1'b1 || o.addr !== wr_addr ||
            o.mask !== wr_mask || o.wd !== wr_data))) begin
          errors++; $display("FAIL rnd_arr_write c%0d: en %0b addr %0d mask %0h want %0b %0d %0h", c, o.en, o.addr, o.mask, wr_mask != 0, wr_addr, wr_mask);
        end
      end
      if (o.ra) begin
        checks++;
        if (o.en !== 1'b1 || o.wm !== 1'b0 || o.addr !== rd_addr) begin
          errors++; $display("FAIL rnd_arr_read c%0d: en %0b wm %0b addr %0d want 1 0 %0d", c, o.en, o.wm, o.addr, rd_addr);
        end
      end
      if (!rd_valid || o.ra) losses = 0;
      else if (credit && o.wa && losses < STARVE_LIMIT) losses++;
    end
    idle();
    for (int k = 0; k < 6 && outst > 0; k++) begin
      advance(o);
      if (o.dq) begin
        checks++;
        if (o.qempty || o.rdat !== o.expd) begin errors++; $display("FAIL rnd_drain_data: got %0h want %0h", o.rdat, o.expd); end
      end
    end
    checks++; if (outst != 0) begin errors++; $display("FAIL rnd_drain_count: got %0d want 0", outst); end
  endtask

  initial begin
    reset = 1'b1;  idle();
    rd_addr = '0;  wr_addr = '0;  wr_mask = '0;  wr_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = rand_data();
    @(posedge clock);
    #1;
    load_mem = 1'b0;
    test_reset();
`ifdef ARRAY_13_INIT_EN
    test_init();
`endif
    test_back_to_back();
    test_masked_write();
    test_backpressure();
    test_starve();
    test_reset_midread();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
